// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: default parameter values shared with the input/output port modules
package input_conditioner_pkg;
  localparam int IN_SIZE_DEF = 2;
  localparam int DEB_CNT_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/input_conditioner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous pin levels
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces switch inputs, flags newly accepted values
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int InSize = IN_SIZE_DEF,
  parameter int DebCnt = DEB_CNT_DEF,
  parameter int CntW = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [InSize-1:0] SW_IN,
  input  logic              RD,
  output logic [InSize-1:0] INPUT,
  output logic              IN_VALID,
  output logic              IN_CHANGE
);
  logic [InSize-1:0] w_sync, r_cand, r_input;
  logic [CntW-1:0]   r_cnt;
  logic              r_valid, r_change;
  sync_2ff #(.W(InSize)) u_sync (
    .clk(CLK),
    .rst(RST),
    .i_d(SW_IN),
    .o_q(w_sync)
  );
  // acceptance happens only once the counter has saturated on a stable candidate
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_input  <= '0;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_change <= 1'b0;
      if (RD) r_valid <= 1'b0;
      if (w_sync != r_cand) begin
        r_cand <= w_sync;
        r_cnt  <= '0;
      end else if (r_cnt < CntW'(DebCnt - 1)) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_cand != r_input) begin
        r_input  <= r_cand;
        r_change <= 1'b1;
        r_valid  <= 1'b1;
      end
    end
  end
  assign INPUT     = r_input;
  assign IN_VALID  = r_valid;
  assign IN_CHANGE = r_change;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner at default parameters
module tb_input_conditioner;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] SW_IN = 2'b00;
  logic       RD = 1'b0;
  logic [1:0] INPUT;
  logic       IN_VALID, IN_CHANGE;
  int n_vec = 0;
  int n_err = 0;

  input_conditioner dut (
    .CLK(CLK), .RST(RST), .SW_IN(SW_IN), .RD(RD),
    .INPUT(INPUT), .IN_VALID(IN_VALID), .IN_CHANGE(IN_CHANGE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    RD = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    SW_IN = 2'b11;
    RD = 1'b1;
    RST = 1'b1;
    tick();
    tick();
    n_vec++; if (INPUT !== 2'b00) begin n_err++; $display("FAIL reset_input got %b want 00", INPUT); end
    n_vec++; if (IN_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", IN_VALID); end
    n_vec++; if (IN_CHANGE !== 1'b0) begin n_err++; $display("FAIL reset_change got %b want 0", IN_CHANGE); end
    RD = 1'b0;
    SW_IN = 2'b00;
    RST = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    SW_IN = 2'b10;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e <= 6) begin
        n_vec++; if (INPUT !== 2'b00 || IN_CHANGE !== 1'b0 || IN_VALID !== 1'b0) begin
          n_err++; $display("FAIL latency_early edge %0d got %b/%b/%b want 00/0/0", e, INPUT, IN_CHANGE, IN_VALID);
        end
      end else if (e == 7) begin
        n_vec++; if (INPUT !== 2'b10) begin n_err++; $display("FAIL latency_input got %b want 10", INPUT); end
        n_vec++; if (IN_CHANGE !== 1'b1) begin n_err++; $display("FAIL latency_change got %b want 1", IN_CHANGE); end
        n_vec++; if (IN_VALID !== 1'b1) begin n_err++; $display("FAIL latency_valid got %b want 1", IN_VALID); end
      end else begin
        n_vec++; if (IN_CHANGE !== 1'b0) begin n_err++; $display("FAIL latency_pulse_end got %b want 0", IN_CHANGE); end
        n_vec++; if (INPUT !== 2'b10) begin n_err++; $display("FAIL latency_hold got %b want 10", INPUT); end
      end
    end
  endtask

  task automatic test_rd();
    RD = 1'b1;
    tick();
    RD = 1'b0;
    n_vec++; if (IN_VALID !== 1'b0) begin n_err++; $display("FAIL rd_clear got %b want 0", IN_VALID); end
    n_vec++; if (INPUT !== 2'b10) begin n_err++; $display("FAIL rd_input got %b want 10", INPUT); end
    RD = 1'b1;
    tick();
    RD = 1'b0;
    tick();
    n_vec++; if (IN_VALID !== 1'b0 || INPUT !== 2'b10 || IN_CHANGE !== 1'b0) begin
      n_err++; $display("FAIL rd_idle got %b/%b/%b want 0/10/0", IN_VALID, INPUT, IN_CHANGE);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    SW_IN = 2'b00;
    repeat (3) tick();
    SW_IN = 2'b11;
    repeat (3) tick();
    SW_IN = 2'b00;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_vec++; if (INPUT !== 2'b00 || IN_CHANGE !== 1'b0 || IN_VALID !== 1'b0) begin
        n_err++; $display("FAIL glitch cycle %0d got %b/%b/%b want 00/0/0", c, INPUT, IN_CHANGE, IN_VALID);
      end
    end
  endtask

  task automatic test_rd_accept();
    SW_IN = 2'b01;
    repeat (6) tick();
    n_vec++; if (INPUT !== 2'b00) begin n_err++; $display("FAIL rdacc_pre got %b want 00", INPUT); end
    RD = 1'b1;
    tick();
    RD = 1'b0;
    n_vec++; if (IN_VALID !== 1'b1) begin n_err++; $display("FAIL rdacc_valid got %b want 1", IN_VALID); end
    n_vec++; if (INPUT !== 2'b01) begin n_err++; $display("FAIL rdacc_input got %b want 01", INPUT); end
    n_vec++; if (IN_CHANGE !== 1'b1) begin n_err++; $display("FAIL rdacc_change got %b want 1", IN_CHANGE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    SW_IN = 2'b11;
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_vec++; if (INPUT !== 2'b00 || IN_VALID !== 1'b0 || IN_CHANGE !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear got %b/%b/%b want 00/0/0", INPUT, IN_VALID, IN_CHANGE);
    end
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) begin
        n_vec++; if (INPUT !== 2'b00 || IN_CHANGE !== 1'b0) begin
          n_err++; $display("FAIL midrst_early edge %0d got %b/%b want 00/0", e, INPUT, IN_CHANGE);
        end
      end else begin
        n_vec++; if (INPUT !== 2'b11 || IN_CHANGE !== 1'b1 || IN_VALID !== 1'b1) begin
          n_err++; $display("FAIL midrst_accept got %b/%b/%b want 11/1/1", INPUT, IN_CHANGE, IN_VALID);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seen [0:3];
    logic [1:0] lvl [0:2];
    int pulses = 0;
    do_reset();
    lvl[0] = 2'b00; lvl[1] = 2'b01; lvl[2] = 2'b00;
    for (int s = 0; s < 4; s++) begin
      SW_IN = lvl[s < 3 ? s : 2];
      for (int c = 0; c < 10; c++) begin
        tick();
        if (IN_CHANGE === 1'b1) begin
          if (pulses < 4) seen[pulses] = INPUT;
          pulses++;
        end
      end
    end
    n_vec++; if (pulses != 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    n_vec++; if (pulses >= 1 && seen[0] !== 2'b01) begin n_err++; $display("FAIL b2b_first got %b want 01", seen[0]); end
    n_vec++; if (pulses >= 2 && seen[1] !== 2'b00) begin n_err++; $display("FAIL b2b_second got %b want 00", seen[1]); end
    n_vec++; if (INPUT !== 2'b00) begin n_err++; $display("FAIL b2b_final got %b want 00", INPUT); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rd();
    test_glitch();
    test_rd_accept();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter InSize, default 2: width of the raw switch input and of the conditioned output.
REQ-002 Parameter DebCnt, default 4: consecutive stable cycles required before a new value is accepted; legal range 2..255.
REQ-003 Parameter CntW, default 8: debounce counter width; SHALL satisfy 2^CntW > DebCnt.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 CLK  input  1  rising-edge system clock.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 SW_IN  input  InSize  raw asynchronous external switch/pin levels.
REQ-008 RD  input  1  one-cycle read acknowledge from the CPU IN instruction.
REQ-009 INPUT  output  InSize  registered, debounced value; feeds input_port.INPUT directly.
REQ-010 IN_VALID  output  1  a new value has been accepted since the last RD.
REQ-011 IN_CHANGE  output  1  one-cycle pulse on the edge where INPUT takes a new value.

Function
REQ-012 Each SW_IN bit SHALL pass through a two-flop synchronizer; only the second stage (sync) is used downstream.
REQ-013 A register cand SHALL hold the candidate value, and a counter cnt SHALL count stable cycles.
REQ-014 If sync != cand on an edge: cand <= sync and cnt <= 0.
REQ-015 Else if cnt < DebCnt-1: cnt <= cnt+1.
REQ-016 Else cnt SHALL saturate at DebCnt-1.
REQ-017 When cnt == DebCnt-1 and sync == cand and cand != INPUT: on that edge INPUT <= cand, IN_CHANGE <= 1, IN_VALID <= 1.
REQ-018 IN_CHANGE SHALL be 0 on every other edge (single-cycle pulse).
REQ-019 Latency: with SW_IN settled before rising edge 1, INPUT SHALL update on rising edge DebCnt+3, i.e. edge 7 at DebCnt=4.
REQ-020 Any SW_IN excursion lasting fewer than DebCnt cycles (as seen at sync) SHALL leave INPUT, IN_VALID and IN_CHANGE unchanged.
REQ-021 A value that settles back to the current INPUT SHALL NOT produce IN_CHANGE or set IN_VALID.
REQ-022 RD == 1 SHALL clear IN_VALID on that edge.
REQ-023 If RD and an acceptance (REQ-017) occur on the same edge, IN_VALID SHALL be 1 (set wins).
REQ-024 RD while IN_VALID == 0 SHALL have no effect.
REQ-025 Multi-bit changes SHALL be accepted atomically: all INPUT bits update on the same edge, never bit-by-bit.
REQ-026 INPUT SHALL change only on acceptance edges; between acceptances it SHALL hold its value.

Reset
REQ-027 RST == 1 at a rising edge SHALL set both synchronizer stages, cand, cnt, INPUT, IN_VALID and IN_CHANGE to 0.
REQ-028 RST SHALL override RD and any pending acceptance on the same edge.
REQ-029 After RST deasserts with SW_IN != 0, the full REQ-019 latency SHALL apply from the first post-reset edge.
REQ-030 A reset asserted mid-count SHALL discard the partial count; no acceptance SHALL occur from pre-reset history.

Structure
REQ-031 The default values of InSize, DebCnt and CntW SHALL live in the shared parameter include file used by the input/output port modules.
REQ-032 The two-flop synchronizer SHALL be a sub-module sync_2ff, parameterized by width and instantiated once with width InSize.
REQ-033 All remaining logic SHALL be a single clocked always block plus output assigns.
REQ-034 No combinational path SHALL exist from SW_IN or RD to any output.

Verification
REQ-035 Reset then SW_IN=2'b10 from edge 1 (DebCnt=4) -> INPUT=2'b10, IN_CHANGE=1 and IN_VALID=1 exactly at edge 7; IN_CHANGE=0 at edge 8.
REQ-036 SW_IN glitches 00->11 for 3 cycles then back to 00 -> INPUT stays 00; IN_CHANGE never asserted.
REQ-037 IN_VALID=1, RD pulse for one cycle -> IN_VALID=0 next edge; INPUT unchanged.
REQ-038 RD asserted on the same edge a new value 01 is accepted -> IN_VALID remains 1 and INPUT=01.
REQ-039 SW_IN=11 held, RST pulsed at edge 5 (mid-count) -> all outputs 0 after the reset edge; INPUT=11 at edge DebCnt+3 counted from the first post-reset edge.
REQ-040 SW_IN 00->01->00, each level held 10 cycles -> exactly two IN_CHANGE pulses; INPUT sequence 01 then 00.
